// File: rtl/sev_seg_scroller.sv
// Scrolls a stored ASCII message right-to-left across NUM_DIGITS seven-segment digits.
// Emits one registered ASCII code per digit, plus a mask that marks padding digits.

module sev_seg_scroller_digit #(
    parameter int PW     = 5,
    parameter int AW     = 3,
    parameter int LW     = 4,
    parameter int OFFSET = 0
) (
    input  logic [PW-1:0] pos,
    input  logic [PW-1:0] period,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] addr,
    output logic          in_msg
);
    logic [PW-1:0] sum;
    logic [PW-1:0] idx;

    // pos < P and OFFSET < NUM_DIGITS, so sum < 2P and one subtract wraps it
    always_comb begin
        sum    = pos + PW'(OFFSET);
        idx    = (sum >= period) ? sum - period : sum;
        addr   = idx[AW-1:0];
        in_msg = (idx < PW'(len));
    end
endmodule

module sev_seg_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 32,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          WrEn,
    input  logic [7:0]                    WrData,
    output logic                          WrReady,
    input  logic                          Clear,
    input  logic                          Start,
    input  logic                          Stop,
    output logic                          Busy,
    output logic [$clog2(MSG_DEPTH):0]    MsgLen,
    output logic [8*NUM_DIGITS-1:0]       DigitCodes,
    output logic [NUM_DIGITS-1:0]         DigitBlank
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic {IDLE, SCROLL} state_t;

    state_t                         state;
    logic [LW-1:0]                  len;
    logic [PW-1:0]                  pos;
    logic [PW-1:0]                  period;
    logic [TW-1:0]                  tick;
    logic [7:0]                     msg [MSG_DEPTH];
    logic [NUM_DIGITS-1:0][AW-1:0]  addr;
    logic [NUM_DIGITS-1:0]          in_msg;
    logic [NUM_DIGITS-1:0][7:0]     codes;
    logic [NUM_DIGITS-1:0]          blank;
    logic                           start_ok;
    logic                           wr_fire;
    logic                           tick_end;

    assign period     = PW'(len) + PW'(NUM_DIGITS);
    assign WrReady    = (state == IDLE) && (len != LW'(MSG_DEPTH));
    assign start_ok   = Start && (len != '0);
    // Higher-priority controls in the same cycle swallow the write
    assign wr_fire    = WrEn && WrReady && !Clear && !Stop && !start_ok;
    assign tick_end   = (tick == TW'(TICK_DIV - 1));
    assign Busy       = (state == SCROLL);
    assign MsgLen     = len;
    assign DigitCodes = codes;
    assign DigitBlank = blank;

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            state <= IDLE;
            len   <= '0;
            pos   <= '0;
            tick  <= '0;
        end else if (Stop) begin
            state <= IDLE;
            pos   <= '0;
            tick  <= '0;
        end else if (start_ok) begin
            state <= SCROLL;
            pos   <= '0;
            tick  <= '0;
        end else if (state == SCROLL) begin
            if (tick_end) begin
                tick <= '0;
                pos  <= (pos == period - PW'(1)) ? '0 : pos + PW'(1);
            end else begin
                tick <= tick + TW'(1);
            end
        end else if (wr_fire) begin
            len <= len + LW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire)
            msg[len[AW-1:0]] <= WrData;
    end

    for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_digit
        sev_seg_scroller_digit #(
            .PW     (PW),
            .AW     (AW),
            .LW     (LW),
            .OFFSET (NUM_DIGITS - 1 - j)
        ) u_digit (
            .pos    (pos),
            .period (period),
            .len    (len),
            .addr   (addr[j]),
            .in_msg (in_msg[j])
        );
    end

    // Frame registers trail pos by one cycle; anything but SCROLL shows all blanks
    always_ff @(posedge Clk) begin
        if (Reset || state != SCROLL) begin
            codes <= {NUM_DIGITS{8'h20}};
            blank <= '1;
        end else begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                codes[j] <= in_msg[j] ? msg[addr[j]] : 8'h20;
                blank[j] <= !in_msg[j];
            end
        end
    end
endmodule

// File: tb/tb_sev_seg_scroller.sv
// Randomized bench for sev_seg_scroller; expected frames come from a queue-based
// model of the scrolling stream indexed by elapsed cycles since Start.

module tb_sev_seg_scroller;
    localparam int ND = 4;
    localparam int MD = 8;
    localparam int TD = 4;

    logic        Clk = 0;
    logic        Reset = 0;
    logic        WrEn = 0;
    logic [7:0]  WrData = 0;
    logic        WrReady;
    logic        Clear = 0;
    logic        Start = 0;
    logic        Stop = 0;
    logic        Busy;
    logic [3:0]  MsgLen;
    logic [31:0] DigitCodes;
    logic [3:0]  DigitBlank;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] model_msg[$];

    sev_seg_scroller #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .TICK_DIV(TD)) dut (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrData(WrData), .WrReady(WrReady),
        .Clear(Clear), .Start(Start), .Stop(Stop), .Busy(Busy), .MsgLen(MsgLen),
        .DigitCodes(DigitCodes), .DigitBlank(DigitBlank)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Stream = message then ND spaces; digit j (0 = rightmost) shows S[(p+ND-1-j) mod P]
    function automatic logic [31:0] exp_codes(int p);
        logic [31:0] r;
        int L, per, k;
        L = model_msg.size();
        per = L + ND;
        r = '0;
        for (int j = 0; j < ND; j++) begin
            k = (p + ND - 1 - j) % per;
            r[8*j +: 8] = (k < L) ? model_msg[k] : 8'h20;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_blank(int p);
        logic [3:0] r;
        int L, per;
        L = model_msg.size();
        per = L + ND;
        for (int j = 0; j < ND; j++)
            r[j] = (((p + ND - 1 - j) % per) >= L);
        return r;
    endfunction

    task automatic do_reset();
        Reset = 1;
        step();
        Reset = 0;
        model_msg.delete();
    endtask

    task automatic write_char(input logic [7:0] c);
        WrEn = 1;
        WrData = c;
        step();
        WrEn = 0;
    endtask

    task automatic pulse_start();
        Start = 1;
        step();
        Start = 0;
    endtask

    task automatic write_random(input int n);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            c = 8'($urandom_range(33, 126));
            write_char(c);
            model_msg.push_back(c);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (DigitCodes !== 32'h20202020 || DigitBlank !== 4'hF || Busy !== 1'b0 ||
            MsgLen !== 4'd0 || WrReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: codes=%h blank=%b busy=%b len=%0d rdy=%b, want 20202020 1111 0 0 1",
                     DigitCodes, DigitBlank, Busy, MsgLen, WrReady);
        end
    endtask

    task automatic test_hi_scroll();
        int per, p;
        do_reset();
        write_char(8'h48); model_msg.push_back(8'h48);
        write_char(8'h49); model_msg.push_back(8'h49);
        per = model_msg.size() + ND;
        pulse_start();
        step();
        tests_run++;
        if (DigitCodes !== 32'h48492020 || DigitBlank !== 4'b0011 || Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hi_first_frame: codes=%h blank=%b busy=%b, want 48492020 0011 1",
                     DigitCodes, DigitBlank, Busy);
        end
        for (int n = 2; n <= per * TD + 2; n++) begin
            step();
            p = ((n - 1) / TD) % per;
            tests_run++;
            if (DigitCodes !== exp_codes(p) || DigitBlank !== exp_blank(p)) begin
                tests_failed++;
                $display("FAIL hi_scroll n=%0d: codes=%h blank=%b, want %h %b",
                         n, DigitCodes, DigitBlank, exp_codes(p), exp_blank(p));
            end
        end
        Stop = 1; step(); Stop = 0;
    endtask

    task automatic test_full();
        int per, p;
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < MD; i++) begin
            tests_run++;
            if (WrReady !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_ready_%0d: rdy=%b, want 1", i, WrReady);
            end
            c = 8'($urandom_range(33, 126));
            write_char(c);
            model_msg.push_back(c);
        end
        tests_run++;
        if (WrReady !== 1'b0 || MsgLen !== 4'd8) begin
            tests_failed++;
            $display("FAIL full_after8: rdy=%b len=%0d, want 0 8", WrReady, MsgLen);
        end
        write_char(8'h5A);
        tests_run++;
        if (MsgLen !== 4'd8) begin
            tests_failed++;
            $display("FAIL full_ninth: len=%0d, want 8", MsgLen);
        end
        per = MD + ND;
        pulse_start();
        for (int n = 1; n <= per * TD + 3; n++) begin
            step();
            p = ((n - 1) / TD) % per;
            tests_run++;
            if (DigitCodes !== exp_codes(p) || DigitBlank !== exp_blank(p)) begin
                tests_failed++;
                $display("FAIL full_scroll n=%0d: codes=%h blank=%b, want %h %b",
                         n, DigitCodes, DigitBlank, exp_codes(p), exp_blank(p));
            end
        end
        Stop = 1; step(); Stop = 0;
    endtask

    task automatic test_empty_start();
        do_reset();
        pulse_start();
        tests_run++;
        if (Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_busy: busy=%b, want 0", Busy);
        end
        step();
        tests_run++;
        if (DigitCodes !== 32'h20202020 || DigitBlank !== 4'hF || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_frame: codes=%h blank=%b busy=%b, want 20202020 1111 0",
                     DigitCodes, DigitBlank, Busy);
        end
    endtask

    task automatic test_stop_start();
        int per, p, run, L;
        do_reset();
        write_random($urandom_range(1, 5));
        L = model_msg.size();
        per = L + ND;
        run = $urandom_range(5, 20);
        pulse_start();
        for (int n = 1; n <= run; n++) begin
            step();
            p = ((n - 1) / TD) % per;
            tests_run++;
            if (DigitCodes !== exp_codes(p) || DigitBlank !== exp_blank(p)) begin
                tests_failed++;
                $display("FAIL stop_pre n=%0d: codes=%h blank=%b, want %h %b",
                         n, DigitCodes, DigitBlank, exp_codes(p), exp_blank(p));
            end
        end
        Stop = 1; Start = 1;
        step();
        Stop = 0; Start = 0;
        tests_run++;
        if (Busy !== 1'b0 || MsgLen !== 4'(L)) begin
            tests_failed++;
            $display("FAIL stop_state: busy=%b len=%0d, want 0 %0d", Busy, MsgLen, L);
        end
        step();
        tests_run++;
        if (DigitCodes !== 32'h20202020 || DigitBlank !== 4'hF) begin
            tests_failed++;
            $display("FAIL stop_blank: codes=%h blank=%b, want 20202020 1111", DigitCodes, DigitBlank);
        end
        pulse_start();
        for (int n = 1; n <= 2 * TD + 1; n++) begin
            step();
            p = ((n - 1) / TD) % per;
            tests_run++;
            if (DigitCodes !== exp_codes(p) || DigitBlank !== exp_blank(p)) begin
                tests_failed++;
                $display("FAIL stop_resume n=%0d: codes=%h blank=%b, want %h %b",
                         n, DigitCodes, DigitBlank, exp_codes(p), exp_blank(p));
            end
        end
        Stop = 1; step(); Stop = 0;
    endtask

    task automatic test_clear();
        do_reset();
        write_random($urandom_range(1, 6));
        pulse_start();
        repeat (6) step();
        Clear = 1; WrEn = 1; WrData = 8'h41;
        step();
        Clear = 0; WrEn = 0;
        model_msg.delete();
        tests_run++;
        if (MsgLen !== 4'd0 || Busy !== 1'b0 || WrReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_state: len=%0d busy=%b rdy=%b, want 0 0 1", MsgLen, Busy, WrReady);
        end
        step();
        tests_run++;
        if (DigitCodes !== 32'h20202020 || DigitBlank !== 4'hF) begin
            tests_failed++;
            $display("FAIL clear_blank: codes=%h blank=%b, want 20202020 1111", DigitCodes, DigitBlank);
        end
    endtask

    task automatic test_reset_mid();
        int per, p, L;
        do_reset();
        write_random($urandom_range(1, 7));
        L = model_msg.size();
        per = L + ND;
        pulse_start();
        WrEn = 1;
        for (int n = 1; n <= 3 * TD; n++) begin
            WrData = 8'($urandom_range(33, 126));
            step();
            p = ((n - 1) / TD) % per;
            tests_run++;
            if (DigitCodes !== exp_codes(p) || DigitBlank !== exp_blank(p) || MsgLen !== 4'(L)) begin
                tests_failed++;
                $display("FAIL scroll_wr n=%0d: codes=%h blank=%b len=%0d, want %h %b %0d",
                         n, DigitCodes, DigitBlank, MsgLen, exp_codes(p), exp_blank(p), L);
            end
        end
        WrEn = 0;
        do_reset();
        tests_run++;
        if (DigitCodes !== 32'h20202020 || DigitBlank !== 4'hF || Busy !== 1'b0 ||
            MsgLen !== 4'd0 || WrReady !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: codes=%h blank=%b busy=%b len=%0d rdy=%b, want 20202020 1111 0 0 1",
                     DigitCodes, DigitBlank, Busy, MsgLen, WrReady);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_hi_scroll();
        test_full();
        test_empty_start();
        test_stop_start();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sev_seg_scroller.md
Name: sev_seg_scroller

Overview:
Sequencer that stores a short ASCII message and scrolls it right-to-left across a bank of seven-segment digits at a fixed rate. Each cycle it presents one 8-bit ASCII code per digit; the top level feeds each code into the existing ASCII-to-7-segment decoder. A per-digit blank mask lets the top level force unused digits dark (7'h7F, active-low). The block sits between the host/switch logic that writes text and the per-digit decoders.

Parameters:
NUM_DIGITS, 6, number of physical digits; digit NUM_DIGITS-1 is leftmost, digit 0 is rightmost.
MSG_DEPTH, 32, message buffer depth in characters; power of two, 2..64.
TICK_DIV, 25000000, clock cycles per scroll step; >= 2.

Ports:
Clk  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-high reset.
WrEn  in  1  append WrData to the message when WrReady=1.
WrData  in  8  ASCII character to append.
WrReady  out  1  high when a write is accepted: state IDLE and buffer not full.
Clear  in  1  empty the buffer and return to IDLE; honoured in any state.
Start  in  1  begin or restart scrolling when MsgLen > 0.
Stop  in  1  halt scrolling and return to IDLE.
Busy  out  1  high in state SCROLL.
MsgLen  out  $clog2(MSG_DEPTH)+1  number of stored characters.
DigitCodes  out  8*NUM_DIGITS  ASCII code for digit j in bits [8j+7:8j].
DigitBlank  out  NUM_DIGITS  bit j high means digit j is showing padding.

Behaviour:
- Reset, and the outputs it sets: IDLE, MsgLen=0, WrReady=1, Busy=0, pos=0, tick counter=0, every DigitCodes byte=8'h20, DigitBlank all 1.
- States:
  - IDLE: accepts writes; outputs held all-blank.
  - SCROLL: window advances on each tick; writes are refused.
- Write: WrEn && WrReady stores WrData at buffer[MsgLen], then MsgLen increments.
  - WrReady=0 when MsgLen==MSG_DEPTH or the state is not IDLE.
  - WrEn while WrReady=0 is ignored; no error flag.
- Input priority, same cycle: Reset > Clear > Stop > Start > WrEn.
- Clear: MsgLen<=0 and state<=IDLE. A simultaneous WrEn is dropped.
- Stop: SCROLL->IDLE; outputs go all-blank the next cycle; buffer is retained. Stop in IDLE has no effect.
- Start:
  - In IDLE with MsgLen>0: go to SCROLL with pos=0 and tick counter=0.
  - In SCROLL: restart from pos=0 and clear the tick counter.
  - With MsgLen==0: ignored, state stays IDLE.
- Virtual stream: S = message[0..L-1] followed by NUM_DIGITS blanks, so period P = L+NUM_DIGITS, where L=MsgLen.
  - Digit j shows S[(pos + NUM_DIGITS-1-j) mod P].
  - A stream index >= L shows code 8'h20 and sets DigitBlank[j]=1.
  - Modulo is done by a single conditional subtract; the sum is always < 2P.
- Tick: the counter counts 0..TICK_DIV-1 in SCROLL only and is held at 0 in IDLE. On the terminal count it wraps to 0 and pos <= (pos==P-1) ? 0 : pos+1.
- Latency: DigitCodes and DigitBlank are registered.
  - They reflect pos one cycle after pos changes.
  - After Start, the first frame appears 1 cycle after the Start edge.
  - The leftmost digit shows message[0].
- L is frozen during SCROLL, because writes are blocked.
- A full buffer of MSG_DEPTH characters is legal; P = MSG_DEPTH+NUM_DIGITS.
- Reset mid-SCROLL returns all state to the reset values on the next edge.

Test Plan:
Bench parameters: NUM_DIGITS=4, MSG_DEPTH=8, TICK_DIV=4.
1. Reset, then write "HI" (0x48,0x49) and pulse Start -> next cycle DigitCodes = {48,49,20,20} (left to right), DigitBlank=4'b0011, Busy=1. Every 4 cycles the window shifts left; after 6 ticks it returns to {48,49,20,20}.
2. Write 8 characters -> WrReady=0 after the 8th accepted write. A 9th WrEn is ignored and MsgLen stays 8. Start -> window wraps with P=12.
3. Start with MsgLen=0 -> Busy stays 0 and outputs stay all 8'h20 with DigitBlank=4'b1111.
4. Mid-scroll, assert Stop and Start in the same cycle -> IDLE and outputs blank the next cycle. A following Start resumes from pos=0 with the message intact.
5. Mid-scroll, assert Clear with WrEn=1 -> MsgLen=0, IDLE, write dropped, WrReady=1 the next cycle.
6. Assert Reset while pos=3 in SCROLL -> the next cycle shows all reset values. WrEn during SCROLL never changes MsgLen.
